// File: rtl/axi_addr_router.sv
// AXI address-channel router: zero-cycle decode/fan-out, in-order slave lock, routing FIFO (rsp_* one cycle after accept).
// Stalls when the FIFO is full or a slave switch waits for drain; AXI_ADDR_ROUTER_DECERR_EN accepts decode misses locally.
module axi_addr_router #(
  parameter int                         NUM_SLAVES      = 5,
  parameter logic [NUM_SLAVES*32-1:0]   SLAVE_BASE      = {32'h4000_0000, 32'h3000_0000, 32'h2000_0000,
                                                           32'h1000_0000, 32'h0000_0000},
  parameter logic [NUM_SLAVES*32-1:0]   SLAVE_MASK      = {5{32'hF000_0000}},
  parameter int                         MAX_OUTSTANDING = 4
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [31:0]                     m_addr,
  input  logic [7:0]                      m_len,
  input  logic [2:0]                      m_size,
  input  logic [1:0]                      m_burst,
  input  logic                            m_valid,
  output logic                            m_ready,
  output logic [NUM_SLAVES*32-1:0]        s_addr,
  output logic [NUM_SLAVES*8-1:0]         s_len,
  output logic [NUM_SLAVES*3-1:0]         s_size,
  output logic [NUM_SLAVES*2-1:0]         s_burst,
  output logic [NUM_SLAVES-1:0]           s_valid,
  input  logic [NUM_SLAVES-1:0]           s_ready,
  output logic                            rsp_valid,
  output logic [2:0]                      rsp_sel,
  output logic                            rsp_decerr,
  input  logic                            rsp_pop,
  output logic [$clog2(MAX_OUTSTANDING):0] outstanding
);

  localparam int              PTR_W = $clog2(MAX_OUTSTANDING);
  localparam logic [PTR_W:0]  DEPTH = (PTR_W+1)'(MAX_OUTSTANDING);

  typedef struct packed {
    logic [2:0] sel;
    logic       decerr;
  } entry_t;

  entry_t           fifo_q [MAX_OUTSTANDING];
  entry_t           fifo_d [MAX_OUTSTANDING];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [2:0]       last_sel_q, last_sel_d;
  logic             last_miss_q, last_miss_d;

  logic       hit;
  logic [2:0] dec_sel;
  logic [2:0] sel;
  logic       miss;
  logic       sel_rdy;
  logic       full;
  logic       stall;
  logic       push;
  logic       pop;
  entry_t     head;

  assign s_addr  = {NUM_SLAVES{m_addr}};
  assign s_len   = {NUM_SLAVES{m_len}};
  assign s_size  = {NUM_SLAVES{m_size}};
  assign s_burst = {NUM_SLAVES{m_burst}};

  // Walk downward so the lowest matching slave index wins.
  always_comb begin
    hit     = 1'b0;
    dec_sel = '0;
    for (int i = NUM_SLAVES-1; i >= 0; i--) begin
      if ((m_addr & SLAVE_MASK[i*32 +: 32]) == SLAVE_BASE[i*32 +: 32]) begin
        hit     = 1'b1;
        dec_sel = 3'(i);
      end
    end
  end

`ifdef AXI_ADDR_ROUTER_DECERR_EN
  assign sel  = dec_sel;
  assign miss = ~hit;
`else
  assign sel  = hit ? dec_sel : 3'(NUM_SLAVES-1);
  assign miss = 1'b0;
`endif

  // Lock uses the registered count: a pop this cycle does not release a switch or a full FIFO.
  assign full  = (count_q == DEPTH);
  assign stall = full | ((count_q != '0) && ((sel != last_sel_q) || (miss != last_miss_q)));

  always_comb begin
    sel_rdy = 1'b0;
    s_valid = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel == 3'(i)) begin
        sel_rdy    = s_ready[i];
        s_valid[i] = m_valid & ~stall & ~miss;
      end
    end
  end

  assign m_ready = ~stall & (miss | sel_rdy);
  assign push    = m_valid & m_ready;
  assign pop     = rsp_pop & (count_q != '0);

  always_comb begin
    fifo_d      = fifo_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    last_sel_d  = last_sel_q;
    last_miss_d = last_miss_q;
    if (push) begin
      fifo_d[wr_ptr_q] = '{sel: sel, decerr: miss};
      wr_ptr_d         = wr_ptr_q + PTR_W'(1);
      last_sel_d       = sel;
      last_miss_d      = miss;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fifo_q      <= '{default: '0};
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      last_sel_q  <= '0;
      last_miss_q <= 1'b0;
    end else begin
      fifo_q      <= fifo_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      last_sel_q  <= last_sel_d;
      last_miss_q <= last_miss_d;
    end
  end

  // decerr is only ever stored as 1 when misses are accepted locally.
  assign head        = fifo_q[rd_ptr_q];
  assign rsp_valid   = (count_q != '0);
  assign rsp_sel     = rsp_valid ? head.sel : 3'd0;
  assign rsp_decerr  = rsp_valid & head.decerr;
  assign outstanding = count_q;

endmodule

// File: tb/tb_axi_addr_router.sv
// Scoreboard bench for axi_addr_router (5 slaves, default map, 4-deep FIFO).
module tb_axi_addr_router;

  logic        clk;
  logic        reset_n;
  logic [31:0] m_addr;
  logic [7:0]  m_len;
  logic [2:0]  m_size;
  logic [1:0]  m_burst;
  logic        m_valid;
  logic        m_ready;
  logic [159:0] s_addr;
  logic [39:0]  s_len;
  logic [14:0]  s_size;
  logic [9:0]   s_burst;
  logic [4:0]  s_valid;
  logic [4:0]  s_ready;
  logic        rsp_valid;
  logic [2:0]  rsp_sel;
  logic        rsp_decerr;
  logic        rsp_pop;
  logic [2:0]  outstanding;

  typedef struct {
    logic [4:0]  sv;
    logic [31:0] addr;
    logic [7:0]  len;
  } acc_t;

  acc_t       acc_q[$];
  logic [3:0] rsp_q[$];
  int         n_chk  = 0;
  int         n_fail = 0;

  axi_addr_router dut (
    .clk(clk), .reset_n(reset_n),
    .m_addr(m_addr), .m_len(m_len), .m_size(m_size), .m_burst(m_burst),
    .m_valid(m_valid), .m_ready(m_ready),
    .s_addr(s_addr), .s_len(s_len), .s_size(s_size), .s_burst(s_burst),
    .s_valid(s_valid), .s_ready(s_ready),
    .rsp_valid(rsp_valid), .rsp_sel(rsp_sel), .rsp_decerr(rsp_decerr), .rsp_pop(rsp_pop),
    .outstanding(outstanding)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One request cycle; expected accept data is queued before the edge for the monitor.
  task automatic beat(input logic v, input logic [31:0] a, input logic [4:0] rdy, input logic pop,
                      input logic exp_rdy, input logic [4:0] exp_sv,
                      input logic [2:0] exp_sel, input logic exp_dec);
    acc_t e;
    m_valid = v;
    m_addr  = a;
    m_len   = a[31:24] ^ a[7:0] ^ 8'h5A;
    s_ready = rdy;
    rsp_pop = pop;
    if (v && exp_rdy) begin
      e.sv   = exp_sv;
      e.addr = a;
      e.len  = m_len;
      acc_q.push_back(e);
      rsp_q.push_back({exp_sel, exp_dec});
    end
    @(negedge clk);
    if (v) chk("m_ready", {63'd0, m_ready}, {63'd0, exp_rdy});
    if (v && !exp_rdy) chk("s_valid_stalled", {59'd0, s_valid}, {59'd0, exp_sv});
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic pop);
    beat(1'b0, 32'h0, 5'b00000, pop, 1'b0, 5'b00000, 3'd0, 1'b0);
  endtask

  // Monitor: checks every accept and every retire against the queued expectations.
  initial begin
    acc_t       e;
    logic [3:0] r;
    forever begin
      @(negedge clk);
      if (reset_n && m_valid && m_ready) begin
        if (acc_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_accept: got accept of 0x%0h, expected none", m_addr);
        end else begin
          e = acc_q.pop_front();
          chk("s_valid", {59'd0, s_valid}, {59'd0, e.sv});
          for (int i = 0; i < 5; i++) chk("s_addr", {32'd0, s_addr[i*32 +: 32]}, {32'd0, e.addr});
          chk("s_len", {24'd0, s_len}, {24'd0, {5{e.len}}});
          chk("s_size_burst", {39'd0, s_size, s_burst}, {39'd0, {5{3'd2}}, {5{2'd1}}});
        end
      end
      if (reset_n && rsp_pop && rsp_valid) begin
        if (rsp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_rsp: got sel %0d, expected empty FIFO", rsp_sel);
        end else begin
          r = rsp_q.pop_front();
          chk("rsp_sel", {61'd0, rsp_sel}, {61'd0, r[3:1]});
          chk("rsp_decerr", {63'd0, rsp_decerr}, {63'd0, r[0]});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0;
    m_valid = 1'b0;
    m_addr  = 32'h0;
    m_len   = 8'h0;
    m_size  = 3'd2;
    m_burst = 2'd1;
    s_ready = 5'b00001;
    rsp_pop = 1'b0;
    #2;
    chk("rst_outstanding", {61'd0, outstanding}, 64'd0);
    chk("rst_rsp", {59'd0, rsp_valid, rsp_sel, rsp_decerr}, 64'd0);
    chk("rst_m_ready", {63'd0, m_ready}, 64'd1);
    chk("rst_s_valid", {59'd0, s_valid}, 64'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Basic route to slave 2, then a same-slave follow-up at the top of its window.
    beat(1'b1, 32'h2000_0040, 5'b00100, 1'b0, 1'b1, 5'b00100, 3'd2, 1'b0);
    chk("r30_rsp_valid", {63'd0, rsp_valid}, 64'd1);
    chk("r30_rsp_sel", {61'd0, rsp_sel}, 64'd2);
    chk("r30_outstanding", {61'd0, outstanding}, 64'd1);
    beat(1'b1, 32'h2FFF_FFFC, 5'b00100, 1'b0, 1'b1, 5'b00100, 3'd2, 1'b0);
    chk("same_slave_out", {61'd0, outstanding}, 64'd2);
    idle(1'b1);
    idle(1'b1);
    chk("drain1_out", {61'd0, outstanding}, 64'd0);

    // Slave switch waits until the registered count is zero.
    beat(1'b1, 32'h1000_0000, 5'b00010, 1'b0, 1'b1, 5'b00010, 3'd1, 1'b0);
    beat(1'b1, 32'h3000_0000, 5'b01000, 1'b0, 1'b0, 5'b00000, 3'd0, 1'b0);
    beat(1'b1, 32'h3000_0000, 5'b01000, 1'b1, 1'b0, 5'b00000, 3'd0, 1'b0);
    chk("switch_out", {61'd0, outstanding}, 64'd0);
    beat(1'b1, 32'h3000_0000, 5'b01000, 1'b0, 1'b1, 5'b01000, 3'd3, 1'b0);
    idle(1'b1);

    // Fill, full-with-pop stall, then wrap with simultaneous push and pop.
    for (int k = 0; k < 4; k++)
      beat(1'b1, 32'h0000_0100 + 32'(k*16), 5'b00001, 1'b0, 1'b1, 5'b00001, 3'd0, 1'b0);
    chk("full_out", {61'd0, outstanding}, 64'd4);
    beat(1'b1, 32'h0000_0500, 5'b00001, 1'b0, 1'b0, 5'b00000, 3'd0, 1'b0);
    beat(1'b1, 32'h0000_0500, 5'b00001, 1'b1, 1'b0, 5'b00000, 3'd0, 1'b0);
    chk("full_pop_out", {61'd0, outstanding}, 64'd3);
    beat(1'b1, 32'h0000_0500, 5'b00001, 1'b0, 1'b1, 5'b00001, 3'd0, 1'b0);
    chk("refill_out", {61'd0, outstanding}, 64'd4);
    idle(1'b1);
    idle(1'b1);
    chk("two_left_out", {61'd0, outstanding}, 64'd2);
    beat(1'b1, 32'h0000_0600, 5'b00001, 1'b1, 1'b1, 5'b00001, 3'd0, 1'b0);
    chk("pushpop_out", {61'd0, outstanding}, 64'd2);
    idle(1'b1);
    idle(1'b1);
    chk("drained_out", {61'd0, outstanding}, 64'd0);
    chk("drained_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    idle(1'b1);
    chk("empty_pop_out", {61'd0, outstanding}, 64'd0);
    beat(1'b1, 32'h4ABC_0000, 5'b10000, 1'b0, 1'b1, 5'b10000, 3'd4, 1'b0);
    chk("wrap_rsp_sel", {61'd0, rsp_sel}, 64'd4);
    idle(1'b1);

    // Decode miss.
`ifdef AXI_ADDR_ROUTER_DECERR_EN
    beat(1'b1, 32'h9000_0000, 5'b00000, 1'b0, 1'b1, 5'b00000, 3'd0, 1'b1);
    chk("miss_decerr", {62'd0, rsp_valid, rsp_decerr}, 64'd3);
    beat(1'b1, 32'h0000_0000, 5'b00001, 1'b0, 1'b0, 5'b00000, 3'd0, 1'b0);
    idle(1'b1);
`else
    beat(1'b1, 32'h9000_0000, 5'b01111, 1'b0, 1'b0, 5'b10000, 3'd0, 1'b0);
    beat(1'b1, 32'h9000_0000, 5'b10000, 1'b0, 1'b1, 5'b10000, 3'd4, 1'b0);
    chk("miss_default", {60'd0, rsp_sel, rsp_decerr}, {60'd0, 3'd4, 1'b0});
    idle(1'b1);
`endif
    chk("miss_drain_out", {61'd0, outstanding}, 64'd0);

    // Asynchronous reset with entries in flight.
    for (int k = 0; k < 3; k++)
      beat(1'b1, 32'h1000_0010 + 32'(k*4), 5'b00010, 1'b0, 1'b1, 5'b00010, 3'd1, 1'b0);
    chk("pre_rst_out", {61'd0, outstanding}, 64'd3);
    m_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_out", {61'd0, outstanding}, 64'd0);
    chk("async_rst_rsp", {59'd0, rsp_valid, rsp_sel, rsp_decerr}, 64'd0);
    rsp_q.delete();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    beat(1'b1, 32'h3000_0000, 5'b01000, 1'b0, 1'b1, 5'b01000, 3'd3, 1'b0);
    chk("post_rst_sel", {61'd0, rsp_sel}, 64'd3);
    chk("post_rst_out", {61'd0, outstanding}, 64'd1);
    idle(1'b1);

    chk("acc_q_empty", 64'(acc_q.size()), 64'd0);
    chk("rsp_q_empty", 64'(rsp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
